// File: rtl/mainmem_port_if.sv
// Request/response bus of the main-memory port. The requester drives the master side, the
// memory model sits on the slave side.
interface mainmem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] address;
  logic        read_write;   // 0 = read, 1 = write
  logic [1:0]  access_size;  // 0 = byte, 1 = half, 2 = word, 3 = reserved
  logic        unsigned_ld;  // 1 = zero-extend sub-word reads
  logic [31:0] data_in;
  logic        resp_valid;
  logic [31:0] data_out;
  logic        error;

  modport master (
    output req_valid,
    output address,
    output read_write,
    output access_size,
    output unsigned_ld,
    output data_in,
    input  req_ready,
    input  resp_valid,
    input  data_out,
    input  error
  );

  modport slave (
    input  req_valid,
    input  address,
    input  read_write,
    input  access_size,
    input  unsigned_ld,
    input  data_in,
    output req_ready,
    output resp_valid,
    output data_out,
    output error
  );
endinterface

// File: rtl/mainmem_port.sv
// Byte-addressed, little-endian main-memory model with a single outstanding request and a
// configurable response latency (IDLE -> WAIT -> RESP). Out-of-range and reserved-size accesses
// answer with error=1 and never touch memory.
// Optional feature: define MAINMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses;
// without it misaligned accesses complete byte by byte.
module mainmem_port #(
  parameter logic [31:0] STARTING_ADDR = 32'h0100_0000,
  parameter int unsigned DEPTH_BYTES   = 32'h0010_0000,
  parameter int unsigned LATENCY       = 1
) (
  input logic           clock,
  input logic           reset_n,
  mainmem_port_if.slave bus
);

  localparam int unsigned AddrW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [2:0]  LatM1 = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  // Request captured on the acceptance edge
  logic [31:0] addr_q;
  logic        rw_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;

  // Response registers; only non-zero while in RESP
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [7:0]  mem_q [DEPTH_BYTES];

  logic        accept;
  logic [31:0] eff_addr;
  logic        eff_rw;
  logic [1:0]  eff_size;
  logic        eff_uns;
  logic [31:0] eff_wdata;
  logic [31:0] offset;
  logic [32:0] end_off;
  logic [2:0]  nbytes;
  logic        misal;
  logic        acc_err;
  logic        enter_resp;
  logic        mem_we;
  logic [AddrW-1:0] idx [4];
  logic [7:0]  rbyte [4];

  assign accept     = (state_q == StIdle) && bus.req_valid;
  assign enter_resp = (state_d == StResp) && (state_q != StResp);

  // State register plus request capture and response data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      addr_q  <= 32'd0;
      rw_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.address;
        rw_q    <= bus.read_write;
        size_q  <= bus.access_size;
        uns_q   <= bus.unsigned_ld;
        wdata_q <= bus.data_in;
      end
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state: WAIT lasts LATENCY cycles, RESP exactly one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (LATENCY == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = LatM1;
          end
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: handshake decoded from state, data/error gated by resp_valid
  always_comb begin
    bus.req_ready  = (state_q == StIdle);
    bus.resp_valid = (state_q == StResp);
    bus.data_out   = (state_q == StResp) ? rdata_q : 32'd0;
    bus.error      = (state_q == StResp) && err_q;
  end

  // With LATENCY=0 the access happens on the acceptance edge, so use the live bus in IDLE
  always_comb begin
    if (state_q == StIdle) begin
      eff_addr  = bus.address;
      eff_rw    = bus.read_write;
      eff_size  = bus.access_size;
      eff_uns   = bus.unsigned_ld;
      eff_wdata = bus.data_in;
    end else begin
      eff_addr  = addr_q;
      eff_rw    = rw_q;
      eff_size  = size_q;
      eff_uns   = uns_q;
      eff_wdata = wdata_q;
    end
  end

  // Range/size check; end offset kept 33 bits wide so the top of the address space cannot wrap
  always_comb begin
    offset = eff_addr - STARTING_ADDR;
    unique case (eff_size)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      2'd2:    nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
    end_off = {1'b0, offset} + 33'(nbytes);
`ifdef MAINMEM_MISALIGN_TRAP_EN
    misal = ((eff_size == 2'd1) && eff_addr[0]) ||
            ((eff_size == 2'd2) && (eff_addr[1:0] != 2'd0));
`else
    misal = 1'b0;
`endif
    acc_err = (eff_addr < STARTING_ADDR) || (end_off > 33'(DEPTH_BYTES)) ||
              (eff_size == 2'd3) || misal;
  end

  // Little-endian byte lanes: lane k lives at offset+k
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      idx[k]   = offset[AddrW-1:0] + AddrW'(k);
      rbyte[k] = mem_q[idx[k]];
    end
  end

  // Response data sampled on the edge entering RESP; sub-word reads extended per unsigned_ld
  always_comb begin
    rdata_d = 32'd0;
    err_d   = 1'b0;
    if (enter_resp) begin
      err_d = acc_err;
      if (!acc_err && !eff_rw) begin
        unique case (eff_size)
          2'd0:    rdata_d = {{24{~eff_uns & rbyte[0][7]}}, rbyte[0]};
          2'd1:    rdata_d = {{16{~eff_uns & rbyte[1][7]}}, rbyte[1], rbyte[0]};
          default: rdata_d = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
        endcase
      end
    end
  end

  // No commit while reset is held, so a write cut off by reset never lands
  assign mem_we = enter_resp && eff_rw && !acc_err && reset_n;

  // Memory array; intentionally not reset
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (3'(k) < nbytes) begin
          mem_q[idx[k]] <= eff_wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mainmem_port.sv
// Directed bench for mainmem_port: four instances (LATENCY 1/0/3/7) share the request fields,
// each with its own req_valid. Expected values are hand-computed constants.
module tb_mainmem_port;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rv;
  logic [31:0] address;
  logic        read_write;
  logic [1:0]  access_size;
  logic        unsigned_ld;
  logic [31:0] data_in;

  logic [3:0]  rdy_v;
  logic [3:0]  rsp_v;
  logic [3:0]  err_v;
  logic [31:0] dout_v [4];

  int n_checks = 0;
  int n_fail   = 0;

  mainmem_port_if bus_if [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign bus_if[g].req_valid   = rv[g];
    assign bus_if[g].address     = address;
    assign bus_if[g].read_write  = read_write;
    assign bus_if[g].access_size = access_size;
    assign bus_if[g].unsigned_ld = unsigned_ld;
    assign bus_if[g].data_in     = data_in;
    assign rdy_v[g]  = bus_if[g].req_ready;
    assign rsp_v[g]  = bus_if[g].resp_valid;
    assign err_v[g]  = bus_if[g].error;
    assign dout_v[g] = bus_if[g].data_out;

    mainmem_port #(
      .STARTING_ADDR (32'h0100_0000),
      .DEPTH_BYTES   ((g == 0) ? 32'h0010_0000 : 32'h0000_0100),
      .LATENCY       ((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 7)
    ) u_dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus_if[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int s);
    case (s)
      0:       return 1;
      1:       return 0;
      2:       return 3;
      default: return 7;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issue one request on instance s (called at a negedge); returns at the negedge showing RESP
  task automatic do_req(input int s, input logic rw, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int cyc);
    int   n;
    logic leak;
    address     = a;
    read_write  = rw;
    access_size = sz;
    unsigned_ld = u;
    data_in     = d;
    rv[s]       = 1'b1;
    n = 0;
    while (!rdy_v[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_ready", 32'(rdy_v[s]), 32'd1);
    @(posedge clk);
    #1 rv[s] = 1'b0;
    cyc  = 0;
    rd   = 32'hx;
    er   = 1'bx;
    leak = 1'b0;
    n    = 0;
    while (cyc == 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (rsp_v[s]) begin
        cyc = n;
        rd  = dout_v[s];
        er  = err_v[s];
      end else if (dout_v[s] != 32'd0 || err_v[s] != 1'b0) begin
        leak = 1'b1;
      end
    end
    check_eq("quiet_outputs", 32'(leak), 32'd0);
  endtask

  task automatic wr(input string tag, input int s, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] d, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          cyc;
    do_req(s, 1'b1, sz, 1'b0, a, d, rd, er, cyc);
    check_eq({tag, "_err"}, 32'(er), 32'(exp_err));
    check_eq({tag, "_data"}, rd, 32'd0);
    check_eq({tag, "_lat"}, cyc, lat_of(s) + 1);
  endtask

  task automatic rd_chk(input string tag, input int s, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          cyc;
    do_req(s, 1'b0, sz, u, a, 32'h0, rd, er, cyc);
    check_eq({tag, "_err"}, 32'(er), 32'(exp_err));
    check_eq({tag, "_data"}, rd, exp_data);
    check_eq({tag, "_lat"}, cyc, lat_of(s) + 1);
  endtask

  // req_valid held high: acceptances must be LATENCY+2 apart, response LATENCY+1 after accept
  task automatic b2b(input string tag, input int s);
    int r [3];
    int nr;
    int first_resp;
    @(negedge clk);
    r          = '{-100, -100, -100};
    nr         = 0;
    first_resp = -100;
    address     = 32'h0100_0000;
    read_write  = 1'b0;
    access_size = 2'd2;
    unsigned_ld = 1'b0;
    rv[s]       = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (rdy_v[s] && nr < 3) begin
        r[nr] = i;
        nr++;
      end
      if (rsp_v[s] && first_resp < 0) first_resp = i;
      @(negedge clk);
    end
    rv[s] = 1'b0;
    repeat (12) @(negedge clk);
    check_eq({tag, "_gap01"}, r[1] - r[0], lat_of(s) + 2);
    check_eq({tag, "_gap12"}, r[2] - r[1], lat_of(s) + 2);
    check_eq({tag, "_resp"}, first_resp - r[0], lat_of(s) + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_w0;
    int n_rsp;
    rst_n       = 1'b0;
    rv          = 4'b0;
    address     = 32'h0;
    read_write  = 1'b0;
    access_size = 2'd0;
    unsigned_ld = 1'b0;
    data_in     = 32'h0;

    // Reset state
    #2;
    check_eq("rst_resp_valid", 32'(rsp_v[0]), 32'd0);
    check_eq("rst_data_out", dout_v[0], 32'd0);
    check_eq("rst_error", 32'(err_v[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 32'(rdy_v[0]), 32'd1);

    // Basic write/read and extension, LATENCY=1
    wr("w_word", 0, 2'd2, 32'h0100_0000, 32'hDEAD_BEEF, 1'b0);
    rd_chk("r_word", 0, 2'd2, 1'b0, 32'h0100_0000, 32'hDEAD_BEEF, 1'b0);
    rd_chk("r_byte_s", 0, 2'd0, 1'b0, 32'h0100_0000, 32'hFFFF_FFEF, 1'b0);
    rd_chk("r_byte_u", 0, 2'd0, 1'b1, 32'h0100_0000, 32'h0000_00EF, 1'b0);
    rd_chk("r_half_s2", 0, 2'd1, 1'b0, 32'h0100_0002, 32'hFFFF_DEAD, 1'b0);
    rd_chk("r_half_u2", 0, 2'd1, 1'b1, 32'h0100_0002, 32'h0000_DEAD, 1'b0);
    rd_chk("r_byte_s3", 0, 2'd0, 1'b0, 32'h0100_0003, 32'hFFFF_FFDE, 1'b0);
    rd_chk("r_half_s0", 0, 2'd1, 1'b0, 32'h0100_0000, 32'hFFFF_BEEF, 1'b0);

    // Range boundaries
    rd_chk("r_below", 0, 2'd2, 1'b0, 32'h00FF_FFFC, 32'h0, 1'b1);
    rd_chk("r_past_end", 0, 2'd2, 1'b0, 32'h010F_FFFE, 32'h0, 1'b1);
    rd_chk("r_top_wrap", 0, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    rd_chk("r_size3", 0, 2'd3, 1'b0, 32'h0100_0000, 32'h0, 1'b1);
    wr("w_last_byte", 0, 2'd0, 32'h010F_FFFF, 32'h0000_005A, 1'b0);
    wr("w_past_end", 0, 2'd2, 32'h010F_FFFE, 32'hA5A5_A5A5, 1'b1);
    rd_chk("r_last_byte", 0, 2'd0, 1'b1, 32'h010F_FFFF, 32'h0000_005A, 1'b0);
    wr("w_below", 0, 2'd2, 32'h00FF_FFFC, 32'h1357_9BDF, 1'b1);
    wr("w_size3", 0, 2'd3, 32'h0100_0000, 32'h1357_9BDF, 1'b1);
    rd_chk("r_unchanged", 0, 2'd2, 1'b0, 32'h0100_0000, 32'hDEAD_BEEF, 1'b0);

    // Sub-word writes touch only their lanes
    wr("w_half", 0, 2'd1, 32'h0100_0000, 32'h1234_ABCD, 1'b0);
    rd_chk("r_after_half", 0, 2'd2, 1'b0, 32'h0100_0000, 32'hDEAD_ABCD, 1'b0);
    wr("w_byte3", 0, 2'd0, 32'h0100_0003, 32'hFFFF_FF77, 1'b0);
    rd_chk("r_after_byte", 0, 2'd2, 1'b0, 32'h0100_0000, 32'h77AD_ABCD, 1'b0);

    // Misaligned word write
`ifdef MAINMEM_MISALIGN_TRAP_EN
    wr("w_misal", 0, 2'd2, 32'h0100_0001, 32'h1122_3344, 1'b1);
    rd_chk("r_misal_word0", 0, 2'd2, 1'b0, 32'h0100_0000, 32'h77AD_ABCD, 1'b0);
    rd_chk("r_misal_half", 0, 2'd1, 1'b0, 32'h0100_0001, 32'h0, 1'b1);
    exp_w0 = 32'h77AD_ABCD;
`else
    wr("w_misal", 0, 2'd2, 32'h0100_0001, 32'h1122_3344, 1'b0);
    rd_chk("r_misal_b1", 0, 2'd0, 1'b1, 32'h0100_0001, 32'h0000_0044, 1'b0);
    rd_chk("r_misal_b2", 0, 2'd0, 1'b1, 32'h0100_0002, 32'h0000_0033, 1'b0);
    rd_chk("r_misal_b3", 0, 2'd0, 1'b1, 32'h0100_0003, 32'h0000_0022, 1'b0);
    rd_chk("r_misal_b4", 0, 2'd0, 1'b1, 32'h0100_0004, 32'h0000_0011, 1'b0);
    rd_chk("r_misal_word0", 0, 2'd2, 1'b0, 32'h0100_0000, 32'h2233_44CD, 1'b0);
    rd_chk("r_misal_half3", 0, 2'd1, 1'b0, 32'h0100_0003, 32'h0000_1122, 1'b0);
    exp_w0 = 32'h2233_44CD;
`endif

    // Other latencies: single write/read plus back-to-back throughput
    for (int s = 1; s < 4; s++) begin
      wr($sformatf("w_lat%0d", lat_of(s)), s, 2'd2, 32'h0100_0020, 32'h0A0B_0C0D ^ 32'(s), 1'b0);
      rd_chk($sformatf("r_lat%0d", lat_of(s)), s, 2'd2, 1'b0, 32'h0100_0020,
             32'h0A0B_0C0D ^ 32'(s), 1'b0);
      b2b($sformatf("b2b_lat%0d", lat_of(s)), s);
    end

    // Reset during WAIT drops the write, LATENCY=3
    wr("w_pre_rst", 2, 2'd2, 32'h0100_0010, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    address     = 32'h0100_0010;
    read_write  = 1'b1;
    access_size = 2'd2;
    data_in     = 32'h1122_3344;
    rv[2]       = 1'b1;
    check_eq("rst_wait_ready", 32'(rdy_v[2]), 32'd1);
    @(posedge clk);
    #1 rv[2] = 1'b0;
    @(negedge clk);
    check_eq("rst_wait_busy", 32'(rdy_v[2]), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_wait_idle", 32'(rdy_v[2]), 32'd1);
    check_eq("rst_wait_rv", 32'(rsp_v[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_rsp = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_v[2]) n_rsp++;
    end
    check_eq("rst_wait_no_resp", n_rsp, 0);
    rd_chk("r_post_rst", 2, 2'd2, 1'b0, 32'h0100_0010, 32'hCAFE_F00D, 1'b0);
    rd_chk("r_mem_kept", 0, 2'd2, 1'b0, 32'h0100_0000, exp_w0, 1'b0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
